// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch port: ready-handshaked request with a
// combinational address and returned instruction word.
interface pc_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_ready;

   modport master (output imem_req, output imem_addr,
                   input  imem_rdata, input imem_ready);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_rdata, output imem_ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register, next-PC select, imem fetch handshake and IF/ID
// register, with a DRAIN state so a redirect never abandons an outstanding fetch.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        pc_src,
   input  logic              id_flush,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              stall,
   pc_fetch_unit_if.master   imem,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc4,
   output logic              if_id_valid
);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_target_q, pend_target_d;
   logic              req_q, req_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic              valid_q, valid_d;

   logic              done;
   logic              redirect;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pc_plus4;

   assign done      = req_q & imem.imem_ready;
   assign redirect  = (pc_src != 2'd0);
   assign pc_plus4  = pc_q + ADDR_W'(4);

   // Targets are word-aligned by construction; low bits are dropped here.
   always_comb begin
      target = pc_plus4;
      case (pc_src)
         2'd1:    target = {branch_target[ADDR_W-1:2], 2'b00};
         2'd2:    target = {jump_target[ADDR_W-1:2], 2'b00};
         2'd3:    target = {jr_target[ADDR_W-1:2], 2'b00};
         default: target = pc_plus4;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      req_d         = 1'b1;
      case (state_q)
         RUN: begin
            if (redirect) begin
               if (done) begin
                  pc_d = target;
               end else begin
                  pend_target_d = target;
                  state_d       = DRAIN;
               end
            end else if (!stall && done) begin
               pc_d = pc_plus4;
            end
         end
         DRAIN: begin
            // Latest redirect wins, even on the cycle the drain completes.
            if (redirect) pend_target_d = target;
            if (done) begin
               pc_d    = redirect ? target : pend_target_q;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (id_flush) begin
         instr_d = 32'h0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (stall) begin
         // hold IF/ID
      end else if (state_q == RUN && !redirect && done) begin
         instr_d = imem.imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC[ADDR_W-1:0];
         pend_target_q <= '0;
         req_q         <= 1'b0;
         instr_q       <= 32'h0;
         pc4_q         <= '0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         req_q         <= req_d;
         instr_q       <= instr_d;
         pc4_q         <= pc4_d;
         valid_q       <= valid_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc4      = pc4_q;
   assign if_id_valid    = valid_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the consumer of the ID-stage jump/branch decision (pc_src, id_flush).
- Holds the PC and selects the next PC: sequential, branch, jump or jump-register.
- Drives a ready-handshaked instruction-memory port and writes the IF/ID pipeline register, honouring hazard stalls and control flushes.
- Handles a redirect that arrives while a fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (instruction width is fixed at 32)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_src  in  2  next-PC select from ID: 0 = PC+4, 1 = branch_target, 2 = jump_target, 3 = jr_target
id_flush  in  1  squash the IF/ID contents (taken branch or jump)
branch_target  in  ADDR_W  branch target computed in ID
jump_target  in  ADDR_W  J/JAL target, already concatenated in ID
jr_target  in  ADDR_W  forwarded rs value for JR
stall  in  1  load-use hazard; hold PC and IF/ID
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address; always equals pc
imem_rdata  in  32  instruction data, valid when imem_ready = 1
imem_ready  in  1  fetch completes in a cycle where imem_req & imem_ready
pc  out  ADDR_W  current fetch PC
if_id_instr  out  32  IF/ID instruction
if_id_pc4  out  ADDR_W  IF/ID PC+4 (used for JAL link and branch offset)
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n = 0) sets:
  - pc = RESET_PC, state = RUN, pend_target = 0
  - if_id_instr = 0 (NOP), if_id_pc4 = 0, if_id_valid = 0, imem_req = 0
- After reset, imem_req = 1 in every cycle.
- imem_addr = pc (combinational).
- Memory rule: while imem_req & !imem_ready, imem_addr must stay stable. An outstanding fetch is never abandoned.
- done = imem_req & imem_ready. redirect = (pc_src != 0).
- Selected target: the bits[1:0] of every target are forced to 00. PC+4 wraps modulo 2^ADDR_W.
- States: RUN, DRAIN.
- RUN, priority redirect > stall > normal:
  - redirect & done:
    - pc <= target; fetched word discarded.
  - redirect & !done:
    - pend_target <= target; state <= DRAIN; pc held.
  - !redirect & stall:
    - pc held; fetched word, if any, discarded and refetched next cycle.
  - !redirect & !stall & done:
    - pc <= pc+4
    - if_id_instr <= imem_rdata, if_id_pc4 <= pc+4, if_id_valid <= 1
  - !redirect & !stall & !done:
    - if_id_valid <= 0 (bubble); pc held.
- DRAIN:
  - pc and imem_addr are held. Every completed word is discarded.
  - A new redirect in DRAIN overwrites pend_target; the latest redirect wins.
  - done: pc <= pend_target (or the new target if redirect is high that cycle); state <= RUN.
  - if_id_valid <= 0 each DRAIN cycle unless stall holds it.
- IF/ID update rules:
  - id_flush = 1 → if_id_instr <= 0, if_id_valid <= 0, if_id_pc4 <= 0. This overrides stall and any load.
  - stall & !id_flush → IF/ID held.
- Simultaneous stall & redirect: the redirect is taken and the flush clears IF/ID. The jump unit asserts flush only for resolved jumps.
- Latency:
  - Zero-wait memory: the instruction at PC N reaches IF/ID on the edge after the cycle pc = N.
  - Taken redirect: one-bubble penalty (the flushed slot).
- Reset mid-DRAIN returns to RUN at RESET_PC. pend_target is lost.

Test Plan:
- Sequential, imem_ready tied 1, RESET_PC = 0 → pc 0, 4, 8, 0xC; if_id_pc4 4, 8, 0xC; if_id_valid = 1 from the second cycle on.
- stall = 1 for 2 cycles at pc = 8 → pc stays 8, IF/ID holds the instruction from addr 4; resumes with addr 8 after release.
- Redirect with ready: pc_src = 2, jump_target = 0x400, id_flush = 1 at pc = 0x10 → next pc = 0x400, if_id_valid = 0 one cycle, then the instruction at 0x400.
- Redirect during wait: imem_ready = 0 for 3 cycles at pc = 0x20, pc_src = 1, branch_target = 0x103 → state DRAIN, imem_addr stays 0x20; on ready the word is discarded and pc = 0x100.
- Double redirect in DRAIN: branch to 0x200, then JR to 0x300 before ready → pc = 0x300 after drain.
- Async reset asserted mid-DRAIN → pc = RESET_PC, if_id_valid = 0, imem_req = 0 immediately; RUN after release.
- Wrap: RESET_PC = 32'hFFFF_FFFC, sequential → next pc = 0.
